// File: rtl/urt_pkg.sv
// Shared definitions for the configurable UART receiver: parity modes and
// receiver FSM state encoding.
package urt_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } urt_state_e;

endpackage

// File: rtl/urt_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a
// selectable reset value so an idle-high line does not look like a start bit.
module urt_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= RST_VAL;
            sync_p1 <= RST_VAL;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/urt_rx_cfg.sv
// Parametrised UART receiver: mid-bit sampling, optional parity, 1 or 2 stop
// bits, and a valid/ready output register with overrun detection.
module urt_rx_cfg
    import urt_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TICK_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    urt_state_e           state;
    logic [TW-1:0]        tick;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr;
    logic                 ferr;
    logic                 vld_p0;
    logic                 rxs;
    logic                 sample;

    function automatic logic parity_check(input logic [DATA_BITS-1:0] d, input logic p);
        logic x;
        x = (^d) ^ p;
        return (PARITY == PAR_EVEN) ? x : (PARITY == PAR_ODD) ? !x : 1'b0;
    endfunction

    urt_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxs)
    );

    assign sample = (tick == TICK_FULL);

    // Stage p0: bit-level FSM; vld_p0 marks the cycle after the last stop sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            tick    <= '0;
            bit_cnt <= '0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            vld_p0  <= 1'b0;
        end else begin
            vld_p0 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rxs) begin
                        state <= ST_START;
                        tick  <= '0;
                    end
                end
                ST_START: begin
                    if (tick == TICK_HALF) begin
                        tick    <= '0;
                        bit_cnt <= '0;
                        perr    <= 1'b0;
                        ferr    <= 1'b0;
                        state   <= rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (sample) begin
                        tick <= '0;
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (sample) begin
                        tick  <= '0;
                        perr  <= parity_check(shreg, rxs);
                        state <= ST_STOP;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (sample) begin
                        tick <= '0;
                        if (!rxs) ferr <= 1'b1;
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt <= '0;
                            vld_p0  <= 1'b1;
                            // A low final stop keeps us out of IDLE so a break cannot retrigger
                            state   <= (ferr || !rxs) ? ST_WAIT_HIGH : ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rxs) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_DATA && sample) shreg <= {rxs, shreg[DATA_BITS-1:1]};
    end

    // Stage p1: output holding register with handshake and overrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (vld_p0) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shreg;
                    parity_err <= perr;
                    frame_err  <= ferr;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid   <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_urt_rx_cfg.sv
// Directed bench for urt_rx_cfg: 8E1 instance (a) and 7O2 instance (b).
module tb_urt_rx_cfg;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd_a, rx_ready_a;
    logic [7:0] rx_data_a;
    logic       rx_valid_a, parity_err_a, frame_err_a, overrun_a;
    logic       rxd_b, rx_ready_b;
    logic [6:0] rx_data_b;
    logic       rx_valid_b, parity_err_b, frame_err_b, overrun_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int tstart_a = 0;

    int         n_rise_a = 0, rise_cyc_a = 0, ov_cnt_a = 0;
    logic [7:0] rec_data_a;
    logic       rec_perr_a, rec_ferr_a, vprev_a = 1'b0;
    int         n_rise_b = 0;
    logic [6:0] rec_data_b [4];
    logic       rec_err_b  [4];
    logic       vprev_b = 1'b0;

    urt_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .rxd(rxd_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .rx_ready(rx_ready_a), .parity_err(parity_err_a), .frame_err(frame_err_a),
        .overrun(overrun_a)
    );

    urt_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .rxd(rxd_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .rx_ready(rx_ready_b), .parity_err(parity_err_b), .frame_err(frame_err_b),
        .overrun(overrun_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Record each rising rx_valid with its payload
    always @(negedge clk) begin
        if (rx_valid_a && !vprev_a) begin
            n_rise_a++;
            rise_cyc_a = cyc;
            rec_data_a = rx_data_a;
            rec_perr_a = parity_err_a;
            rec_ferr_a = frame_err_a;
        end
        vprev_a = rx_valid_a;
        if (overrun_a) ov_cnt_a++;
        if (rx_valid_b && !vprev_b) begin
            if (n_rise_b < 4) begin
                rec_data_b[n_rise_b] = rx_data_b;
                rec_err_b[n_rise_b]  = parity_err_b | frame_err_b;
            end
            n_rise_b++;
        end
        vprev_b = rx_valid_b;
    end

    task automatic drive_a(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (i == 0) tstart_a = cyc + 1;
            rxd_a = bits[i];
            repeat (16) @(negedge clk);
        end
        rxd_a = 1'b1;
    endtask

    task automatic drive_b(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rxd_b = bits[i];
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        if (rx_valid_a !== 1'b0) begin failures++; $display("FAIL reset_valid act=%b exp=0", rx_valid_a); end
        checks++;
        if (rx_data_a !== 8'h00) begin failures++; $display("FAIL reset_data act=%h exp=00", rx_data_a); end
        checks++;
        if (parity_err_a !== 1'b0) begin failures++; $display("FAIL reset_perr act=%b exp=0", parity_err_a); end
        checks++;
        if (frame_err_a !== 1'b0) begin failures++; $display("FAIL reset_ferr act=%b exp=0", frame_err_a); end
        checks++;
        if (overrun_a !== 1'b0) begin failures++; $display("FAIL reset_ovr act=%b exp=0", overrun_a); end
        checks++;
    endtask

    task automatic test_parity_ok;
        int n0;
        n0 = n_rise_a;
        drive_a({5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11);
        for (int i = 0; i < 100 && n_rise_a == n0; i++) @(negedge clk);
        if (n_rise_a !== n0 + 1) begin failures++; $display("FAIL ok_count act=%0d exp=%0d", n_rise_a - n0, 1); end
        checks++;
        if (rec_data_a !== 8'hA5) begin failures++; $display("FAIL ok_data act=%h exp=a5", rec_data_a); end
        checks++;
        if (rec_perr_a !== 1'b0 || rec_ferr_a !== 1'b0) begin
            failures++; $display("FAIL ok_flags act=%b%b exp=00", rec_perr_a, rec_ferr_a);
        end
        checks++;
        if (rise_cyc_a - tstart_a !== 171) begin
            failures++; $display("FAIL ok_latency act=%0d exp=171", rise_cyc_a - tstart_a);
        end
        checks++;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_parity_err;
        int n0;
        n0 = n_rise_a;
        drive_a({5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11);
        for (int i = 0; i < 100 && n_rise_a == n0; i++) @(negedge clk);
        if (n_rise_a !== n0 + 1) begin failures++; $display("FAIL perr_count act=%0d exp=1", n_rise_a - n0); end
        checks++;
        if (rec_data_a !== 8'hA5) begin failures++; $display("FAIL perr_data act=%h exp=a5", rec_data_a); end
        checks++;
        if (rec_perr_a !== 1'b1 || rec_ferr_a !== 1'b0) begin
            failures++; $display("FAIL perr_flags act=%b%b exp=10", rec_perr_a, rec_ferr_a);
        end
        checks++;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_frame_err;
        int n0;
        n0 = n_rise_a;
        drive_a({6'b0, 1'b0, 8'h0F, 1'b0}, 10);
        rxd_a = 1'b0;
        repeat (48) @(negedge clk);
        rxd_a = 1'b1;
        repeat (32) @(negedge clk);
        if (n_rise_a !== n0 + 1) begin failures++; $display("FAIL brk_count act=%0d exp=1", n_rise_a - n0); end
        checks++;
        if (rec_data_a !== 8'h0F || rec_ferr_a !== 1'b1) begin
            failures++; $display("FAIL brk_char act=%h/%b exp=0f/1", rec_data_a, rec_ferr_a);
        end
        checks++;
        drive_a({5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11);
        for (int i = 0; i < 100 && n_rise_a == n0 + 1; i++) @(negedge clk);
        if (n_rise_a !== n0 + 2) begin failures++; $display("FAIL after_brk_count act=%0d exp=2", n_rise_a - n0); end
        checks++;
        if (rec_data_a !== 8'h3C) begin failures++; $display("FAIL after_brk_data act=%h exp=3c", rec_data_a); end
        checks++;
        if (rec_perr_a !== 1'b0 || rec_ferr_a !== 1'b0) begin
            failures++; $display("FAIL after_brk_flags act=%b%b exp=00", rec_perr_a, rec_ferr_a);
        end
        checks++;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_glitch;
        int n0;
        n0 = n_rise_a;
        rxd_a = 1'b0;
        repeat (5) @(negedge clk);
        rxd_a = 1'b1;
        repeat (200) @(negedge clk);
        if (n_rise_a !== n0) begin failures++; $display("FAIL glitch_count act=%0d exp=0", n_rise_a - n0); end
        checks++;
        drive_a({5'b0, 1'b1, 1'b0, 8'h55, 1'b0}, 11);
        for (int i = 0; i < 100 && n_rise_a == n0; i++) @(negedge clk);
        if (n_rise_a !== n0 + 1) begin failures++; $display("FAIL post_glitch_count act=%0d exp=1", n_rise_a - n0); end
        checks++;
        if (rec_data_a !== 8'h55 || rec_perr_a !== 1'b0 || rec_ferr_a !== 1'b0) begin
            failures++; $display("FAIL post_glitch_char act=%h/%b%b exp=55/00", rec_data_a, rec_perr_a, rec_ferr_a);
        end
        checks++;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_overrun;
        int n0, o0;
        n0 = n_rise_a;
        o0 = ov_cnt_a;
        rx_ready_a = 1'b0;
        drive_a({5'b0, 1'b1, 1'b0, 8'h11, 1'b0}, 11);
        drive_a({5'b0, 1'b1, 1'b0, 8'h22, 1'b0}, 11);
        repeat (20) @(negedge clk);
        if (rx_valid_a !== 1'b1) begin failures++; $display("FAIL ovr_valid act=%b exp=1", rx_valid_a); end
        checks++;
        if (rx_data_a !== 8'h11) begin failures++; $display("FAIL ovr_data act=%h exp=11", rx_data_a); end
        checks++;
        if (ov_cnt_a - o0 !== 1) begin failures++; $display("FAIL ovr_pulse act=%0d exp=1", ov_cnt_a - o0); end
        checks++;
        if (n_rise_a - n0 !== 1) begin failures++; $display("FAIL ovr_rises act=%0d exp=1", n_rise_a - n0); end
        checks++;
        rx_ready_a = 1'b1;
        @(negedge clk);
        if (rx_valid_a !== 1'b0) begin failures++; $display("FAIL accept_valid act=%b exp=0", rx_valid_a); end
        checks++;
        if (rx_data_a !== 8'h11) begin failures++; $display("FAIL accept_hold act=%h exp=11", rx_data_a); end
        checks++;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int n0;
        logic [15:0] fr;
        n0 = n_rise_b;
        fr = {5'b0, 1'b1, 1'b1, 1'b0, 7'h7F, 1'b0};
        drive_b(fr, 11);
        drive_b(fr, 11);
        drive_b(fr, 4);
        if (n_rise_b - n0 !== 2) begin failures++; $display("FAIL b2b_count act=%0d exp=2", n_rise_b - n0); end
        checks++;
        for (int k = 0; k < 2; k++) begin
            if (n0 + k < 4) begin
                if (rec_data_b[n0+k] !== 7'h7F || rec_err_b[n0+k] !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_char%0d act=%h/%b exp=7f/0", k, rec_data_b[n0+k], rec_err_b[n0+k]);
                end
                checks++;
            end
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        if (rx_data_b !== 7'h00 || rx_valid_b !== 1'b0) begin
            failures++; $display("FAIL midrst_out act=%h/%b exp=00/0", rx_data_b, rx_valid_b);
        end
        checks++;
        if (parity_err_b !== 1'b0 || frame_err_b !== 1'b0 || overrun_b !== 1'b0) begin
            failures++; $display("FAIL midrst_flags act=%b%b%b exp=000", parity_err_b, frame_err_b, overrun_b);
        end
        checks++;
        rxd_b = 1'b1;
        rst = 1'b1;
        repeat (16 * 12) @(negedge clk);
        if (n_rise_b - n0 !== 2 || rx_valid_b !== 1'b0) begin
            failures++; $display("FAIL no_third act=%0d/%b exp=2/0", n_rise_b - n0, rx_valid_b);
        end
        checks++;
    endtask

    initial begin
        rst        = 1'b0;
        rxd_a      = 1'b1;
        rxd_b      = 1'b1;
        rx_ready_a = 1'b1;
        rx_ready_b = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        test_parity_ok();
        test_parity_err();
        test_frame_err();
        test_glitch();
        test_overrun();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
